conv_result_sink: RTL and testbench
===================================

Name: conv_result_sink

Overview:
Synthesisable capture stage behind the convolution core. It collects the per-frame result stream (accepted only while running_i and valid_i are both high) into a show-ahead FIFO and exposes a ready/valid read port. It tracks frame boundaries from running_i, counts results and checks the count against the expected per-frame total. It also accumulates a lane-wise checksum and raises sticky error flags. It generalises single-channel result dumping to CH parallel channels with back-pressure and on-chip checking.

Parameters:
DATA_WIDTH, 32, width of one channel result
CH, 1, number of parallel result channels packed in data_i
DEPTH, 16, FIFO entries; power of 2, minimum 2
EXP_COUNT, 9604, expected results per frame ((N-2)^2 for N=100)
CNT_W, 32, width of result counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
running_i  in  1  core frame-active flag
valid_i  in  1  result valid for this cycle
data_i  in  CH*DATA_WIDTH  results, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
rd_ready_i  in  1  consumer accepts head word
rd_valid_o  out  1  FIFO non-empty
rd_data_o  out  CH*DATA_WIDTH  FIFO head word
rd_last_o  out  1  head word is final word of frame
busy_o  out  1  state != IDLE
frame_done_o  out  1  one-cycle pulse at end of frame
count_o  out  CNT_W  valid samples seen this frame, saturating
checksum_o  out  DATA_WIDTH  sum mod 2^DATA_WIDTH of all channels of all accepted words
err_overflow_o  out  1  sticky: sample dropped on full FIFO
err_count_o  out  1  sticky: frame count != EXP_COUNT

Behaviour:
- Reset: all outputs are 0. FIFO is emptied, state = IDLE, running_q = 0, sticky errors are cleared. Reset mid-frame aborts the frame with no frame_done_o pulse.
- running_q is running_i registered one cycle. Rise = running_i & ~running_q. Fall = ~running_i & running_q.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: on rise, clear count_o and checksum_o and go to CAPTURE. The sample on the rise cycle is itself captured if valid_i=1.
- CAPTURE: push when running_i & valid_i. On fall, go to DRAIN. valid_i is ignored in the fall cycle and whenever running_i=0.
- DRAIN: no pushes. When the FIFO is empty (including immediately after entry), go to DONE.
- DONE: frame_done_o=1 for exactly this cycle. Set err_count_o if count_o != EXP_COUNT. Next state is IDLE.
- A rise seen while in DRAIN or DONE is not honoured. It requires a fresh rise from IDLE, so the core must hold running_i low for at least 2 cycles after DONE.
- Push accept: the FIFO is not full, or it is full and a pop happens in the same cycle.
- Full FIFO without a same-cycle pop: the word is dropped and err_overflow_o is set. count_o still increments, checksum_o does not.
- count_o increments on every running_i & valid_i sample in CAPTURE and saturates at 2^CNT_W-1.
- checksum_o adds the sum of all CH channels of each accepted word, modulo 2^DATA_WIDTH, updated one cycle after the push.
- Latency: a word pushed on edge t is visible as rd_valid_o=1 with rd_data_o at that word from t+1. A pop occurs on an edge where rd_valid_o & rd_ready_i. Pointers wrap modulo DEPTH.
- rd_data_o is 0 when empty.
- rd_last_o = rd_valid_o & (state==DRAIN) & (fifo occupancy==1).
- Simultaneous push and pop with the FIFO empty: the pop is ignored (rd_valid_o=0) and the push proceeds.
- Sticky errors persist across frames until rst.

Test Plan:
1. CH=2, DW=8, DEPTH=4, EXP_COUNT=5, rd_ready_i=1. Drive 5 valid words {1,2}..{9,10} under running_i. Expect the same 5 words out in order, rd_last_o on the 5th, count_o=5, checksum_o=55, one frame_done_o pulse, no errors.
2. Same setup with rd_ready_i=0 throughout and 6 valid words. Expect words 5 and 6 dropped and err_overflow_o=1. Then raise rd_ready_i: exactly 4 words drain, count_o=6, err_count_o=1 at DONE.
3. Full FIFO, rd_ready_i=1 and valid_i=1 in the same cycle. Expect the push accepted, occupancy stays 4, no overflow.
4. running_i pulses high for 3 cycles with valid_i=0. Expect frame_done_o 2 cycles after the fall, count_o=0, err_count_o=1.
5. Assert rst mid-CAPTURE with 2 words buffered. Next cycle: rd_valid_o=0, busy_o=0, count_o=0, errors 0, and no frame_done_o.
6. valid_i=1 while running_i=0 in IDLE. Expect nothing pushed and count_o unchanged.

Source files
------------

// File: rtl/conv_result_sink.sv
// conv_result_sink
//   Capture stage behind the convolution core. Results presented while
//   running_i and valid_i are both high are buffered in a show-ahead FIFO.
//   The FIFO is read through a ready/valid port. The block follows frame
//   boundaries from running_i, counts the results of each frame and
//   accumulates a checksum over them. Sticky flags record dropped samples
//   and frames whose result count was wrong.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   running_i       core frame-active flag (rise/fall mark frame bounds)
//   valid_i         result valid this cycle
//   data_i          CH results, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_ready_i      consumer takes the head word
//   rd_valid_o      FIFO non-empty
//   rd_data_o       FIFO head word (0 when empty)
//   rd_last_o       head word is the final word of the frame
//   busy_o          frame in progress (state != IDLE)
//   frame_done_o    single-cycle end-of-frame pulse
//   count_o         samples seen this frame, saturating
//   checksum_o      mod-2^DATA_WIDTH sum of all channels of accepted words
//   err_overflow_o  sticky: a sample was dropped on a full FIFO
//   err_count_o     sticky: a frame ended with count_o != EXP_COUNT
//
// FSM states
//   state     | meaning
//   ----------+--------------------------------------------------------
//   S_IDLE    | waiting for a rising edge of running_i
//   S_CAPTURE | frame active, pushing running_i & valid_i samples
//   S_DRAIN   | frame ended, waiting for the consumer to empty the FIFO
//   S_DONE    | one-cycle end-of-frame, frame_done_o asserted

module conv_result_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = 1,
    parameter int DEPTH      = 16,
    parameter int EXP_COUNT  = 9604,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     running_i,
    input  logic                     valid_i,
    input  logic [CH*DATA_WIDTH-1:0] data_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [CH*DATA_WIDTH-1:0] rd_data_o,
    output logic                     rd_last_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic [CNT_W-1:0]         count_o,
    output logic [DATA_WIDTH-1:0]    checksum_o,
    output logic                     err_overflow_o,
    output logic                     err_count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam logic [OW-1:0]    FULL_OCC = OW'(DEPTH);
    localparam logic [OW-1:0]    ONE_OCC  = OW'(1);
    localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXP_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic running_q;

    logic [CH*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]            occ_q, occ_d;

    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic [DATA_WIDTH-1:0] sum_pend_q, sum_pend_d;
    logic                  sum_pend_vld_q;
    logic                  err_overflow_q, err_count_q;

    logic rise, fall, frame_start, sample;
    logic fifo_empty, fifo_full, pop, push, drop;
    logic [DATA_WIDTH-1:0] word_sum;

    // ---------------------------------------------------------------
    // Frame edge detection and sample qualification
    // ---------------------------------------------------------------
    assign rise        = running_i & ~running_q;
    assign fall        = ~running_i & running_q;
    assign frame_start = (state_q == S_IDLE) & rise;

    // The rise cycle already belongs to the new frame; the fall cycle is
    // excluded automatically because running_i is low there.
    assign sample = running_i & valid_i & ((state_q == S_CAPTURE) | frame_start);

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == FULL_OCC);

    // A pop on an empty FIFO is meaningless, so pop is gated by non-empty.
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop  = ~fifo_empty & rd_ready_i;
    assign push = sample & (~fifo_full | pop);
    assign drop = sample & fifo_full & ~pop;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + ONE_OCC;
            2'b01:   occ_d = occ_q - ONE_OCC;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        word_sum = '0;
        for (int k = 0; k < CH; k++) begin
            word_sum = word_sum + data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ---------------------------------------------------------------
    // Count and checksum
    // ---------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if (frame_start) begin
            count_d = '0;
        end
        if (sample && !(&count_d)) begin
            count_d = count_d + CNT_W'(1);
        end
    end

    // The checksum lags the push by one cycle through sum_pend_q. Any
    // pending term at frame start would belong to the previous frame and
    // is discarded together with the old total.
    always_comb begin
        sum_pend_d = push ? word_sum : '0;
        if (frame_start) begin
            checksum_d = '0;
        end else if (sum_pend_vld_q) begin
            checksum_d = checksum_q + sum_pend_q;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rise)       state_d = S_CAPTURE;
            S_CAPTURE: if (fall)       state_d = S_DRAIN;
            S_DRAIN:   if (fifo_empty) state_d = S_DONE;
            S_DONE:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            running_q      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            count_q        <= '0;
            checksum_q     <= '0;
            sum_pend_q     <= '0;
            sum_pend_vld_q <= 1'b0;
            err_overflow_q <= 1'b0;
            err_count_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            running_q      <= running_i;
            occ_q          <= occ_d;
            count_q        <= count_d;
            checksum_q     <= checksum_d;
            sum_pend_q     <= sum_pend_d;
            sum_pend_vld_q <= push;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                err_overflow_q <= 1'b1;
            end
            // The count is final once DRAIN is reached, so the flag is
            // raised on entry to DONE and is visible alongside frame_done_o.
            if ((state_q == S_DRAIN) && fifo_empty && (count_q != EXP_CNT)) begin
                err_count_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only exposed while occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign rd_valid_o     = ~fifo_empty;
    assign rd_data_o      = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign rd_last_o      = ~fifo_empty & (state_q == S_DRAIN) & (occ_q == ONE_OCC);
    assign busy_o         = (state_q != S_IDLE);
    assign frame_done_o   = (state_q == S_DONE);
    assign count_o        = count_q;
    assign checksum_o     = checksum_q;
    assign err_overflow_o = err_overflow_q;
    assign err_count_o    = err_count_q;

endmodule

// File: tb/tb_conv_result_sink.sv
module tb_conv_result_sink;

    localparam int DW   = 8;
    localparam int CH   = 2;
    localparam int DEP  = 4;
    localparam int EXP  = 5;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            running_i = 1'b0;
    logic            valid_i = 1'b0;
    logic [CH*DW-1:0] data_i = '0;
    logic            rd_ready_i = 1'b0;
    logic            rd_valid_o;
    logic [CH*DW-1:0] rd_data_o;
    logic            rd_last_o;
    logic            busy_o;
    logic            frame_done_o;
    logic [CW-1:0]   count_o;
    logic [DW-1:0]   checksum_o;
    logic            err_overflow_o;
    logic            err_count_o;

    conv_result_sink #(
        .DATA_WIDTH(DW), .CH(CH), .DEPTH(DEP), .EXP_COUNT(EXP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .running_i(running_i), .valid_i(valid_i),
        .data_i(data_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .count_o(count_o), .checksum_o(checksum_o),
        .err_overflow_o(err_overflow_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] w(input int k);
        logic [7:0] hi, lo;
        hi = 8'(2 * k);
        lo = 8'(2 * k - 1);
        return {hi, lo};
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 frame running, 2 waiting for empty, 3 end-of-frame
    int          m_phase;
    bit          m_run_prev;
    logic [15:0] m_q[$];
    int          m_cnt;
    int          m_csum;
    bit          m_eov, m_ecnt, m_live;
    bit          m_rise, m_fall, m_smp, m_pop, m_empty;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_run_prev = 0; m_q.delete(); m_cnt = 0; m_csum = 0;
            m_eov = 0; m_ecnt = 0; m_live = 1;
        end else begin
            m_rise  = running_i && !m_run_prev;
            m_fall  = !running_i && m_run_prev;
            m_empty = (m_q.size() == 0);
            m_smp   = running_i && valid_i && (m_phase == 1 || (m_phase == 0 && m_rise));
            m_pop   = !m_empty && rd_ready_i;
            if (m_phase == 0 && m_rise) begin
                m_cnt = 0;
                m_csum = 0;
            end
            if (m_smp && m_cnt < CMAX) m_cnt++;
            if (m_pop) void'(m_q.pop_front());
            if (m_smp) begin
                if (m_q.size() < DEP) begin
                    m_q.push_back(data_i);
                    m_csum = (m_csum + int'(data_i[7:0]) + int'(data_i[15:8])) % 256;
                end else begin
                    m_eov = 1;
                end
            end
            case (m_phase)
                0: if (m_rise) m_phase = 1;
                1: if (m_fall) m_phase = 2;
                2: if (m_empty) m_phase = 3;
                default: begin
                    if (m_cnt != EXP) m_ecnt = 1;
                    m_phase = 0;
                end
            endcase
            m_run_prev = running_i;
        end
    end

    // ---------------- compare + read-side monitor ----------------
    logic [15:0] pop_q[$];
    int          done_cnt, last_cnt;
    logic [15:0] last_word;

    always @(negedge clk) begin
        if (m_live) begin
            chk("rd_valid", rd_valid_o, m_q.size() != 0);
            chk("rd_data", rd_data_o, (m_q.size() != 0) ? m_q[0] : 16'h0);
            chk("rd_last", rd_last_o, (m_q.size() == 1) && (m_phase == 2));
            chk("busy", busy_o, m_phase != 0);
            chk("frame_done", frame_done_o, m_phase == 3);
            chk("count", count_o, m_cnt);
            if (m_phase != 1) chk("checksum", checksum_o, m_csum);
            chk("err_overflow", err_overflow_o, m_eov);
            if (m_phase != 3) chk("err_count", err_count_o, m_ecnt);
        end
        if (!rst) begin
            if (rd_valid_o && rd_ready_i) begin
                pop_q.push_back(rd_data_o);
                if (rd_last_o) begin
                    last_cnt++;
                    last_word = rd_data_o;
                end
            end
            if (frame_done_o) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit run, input bit vld, input logic [15:0] d, input bit rdy);
        @(posedge clk); #1;
        running_i = run; valid_i = vld; data_i = d; rd_ready_i = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; running_i = 0; valid_i = 0; data_i = '0; rd_ready_i = 0;
        @(posedge clk); #1;
        rst = 0;
        pop_q.delete(); done_cnt = 0; last_cnt = 0; last_word = '0;
    endtask

    task automatic wait_done(input int max, output int at_cyc);
        bit ok;
        ok = 0;
        at_cyc = -1;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (frame_done_o) begin
                ok = 1;
                at_cyc = cyc;
            end
        end
        chk("done_seen", ok, 1);
    endtask

    task automatic chk_pops(input string name, input int n);
        chk({name, "_npop"}, pop_q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk({name, "_word"}, (i < pop_q.size()) ? pop_q[i] : 16'hdead, w(i + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, fc;
        done_cnt = 0; last_cnt = 0; last_word = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_rd_valid", rd_valid_o, 0);
        chk("reset_count", count_o, 0);
        do_reset();

        // 1: five words streamed with the consumer always ready
        for (int k = 1; k <= 5; k++) drive(1, 1, w(k), 1);
        drive(0, 0, '0, 1);
        wait_done(20, dc);
        chk("t1_count", count_o, 5);
        chk("t1_checksum", checksum_o, 55);
        chk_pops("t1", 5);
        drive(0, 0, '0, 1);
        @(negedge clk);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_err_ov", err_overflow_o, 0);
        chk("t1_err_cnt", err_count_o, 0);

        // 6: valid while not running in IDLE
        for (int k = 0; k < 3; k++) drive(0, 1, w(9), 1);
        @(negedge clk);
        chk("t6_count", count_o, 5);
        chk("t6_rd_valid", rd_valid_o, 0);
        chk("t6_busy", busy_o, 0);

        // 2: consumer stalled, six words into a four-deep FIFO
        do_reset();
        for (int k = 1; k <= 6; k++) drive(1, 1, w(k), 0);
        drive(0, 0, '0, 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t2_err_ov", err_overflow_o, 1);
        chk("t2_count", count_o, 6);
        chk("t2_busy", busy_o, 1);
        drive(0, 0, '0, 1);
        wait_done(20, dc);
        chk_pops("t2", 4);
        chk("t2_checksum", checksum_o, 36);
        chk("t2_last_cnt", last_cnt, 1);
        chk("t2_last_word", last_word, w(4));
        drive(0, 0, '0, 1);
        @(negedge clk);
        chk("t2_err_cnt", err_count_o, 1);

        // 3: push and pop together on a full FIFO
        do_reset();
        for (int k = 1; k <= 4; k++) drive(1, 1, w(k), 0);
        drive(1, 1, w(5), 1);
        drive(1, 0, '0, 0);
        @(negedge clk);
        chk("t3_err_ov", err_overflow_o, 0);
        chk("t3_count", count_o, 5);
        drive(0, 0, '0, 1);
        wait_done(20, dc);
        chk_pops("t3", 5);
        chk("t3_last_word", last_word, w(5));
        chk("t3_checksum", checksum_o, 55);
        drive(0, 0, '0, 1);
        @(negedge clk);
        chk("t3_err_ov_end", err_overflow_o, 0);
        chk("t3_err_cnt", err_count_o, 0);

        // 4: empty frame, running high for three cycles
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, 0, '0, 1);
        drive(0, 0, '0, 1);
        fc = cyc;
        wait_done(20, dc);
        chk("t4_done_latency", dc - fc, 2);
        chk("t4_count", count_o, 0);
        drive(0, 0, '0, 1);
        @(negedge clk);
        chk("t4_err_cnt", err_count_o, 1);

        // 5: reset in the middle of a frame with two words buffered
        drive(1, 1, w(1), 0);
        drive(1, 1, w(2), 0);
        drive(1, 0, '0, 0);
        @(negedge clk);
        chk("t5_pre_busy", busy_o, 1);
        do_reset();
        @(negedge clk);
        chk("t5_rd_valid", rd_valid_o, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_count", count_o, 0);
        chk("t5_err_ov", err_overflow_o, 0);
        chk("t5_err_cnt", err_count_o, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, '0, 1);
        @(negedge clk);
        chk("t5_no_done", done_cnt, 0);

        // 7: count saturation and checksum wrap over 17 samples
        do_reset();
        for (int k = 1; k <= 17; k++) drive(1, 1, w(k), 1);
        drive(0, 0, '0, 1);
        wait_done(20, dc);
        chk("t7_count_sat", count_o, 15);
        chk("t7_checksum", checksum_o, 83);
        drive(0, 0, '0, 1);
        @(negedge clk);
        chk("t7_err_cnt", err_count_o, 1);
        chk("t7_err_ov", err_overflow_o, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
